// File: rtl/cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// cache_refill_ctrl: writes a dirty victim line back to memory, then refills
// the missed line, 16 beats each way. Revision: 1.0
// ============================================================================
module cache_refill_ctrl #(
  parameter  int LINE_BYTES = 64,
  parameter  int MEM_WIDTH  = 32,
  localparam int LINE_BITS  = LINE_BYTES * 8,
  localparam int BEATS      = LINE_BITS / MEM_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [31:0]          req_addr,
  input  logic                 req_wb,
  input  logic [31:0]          wb_addr,
  input  logic [LINE_BITS-1:0] wb_data,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [MEM_WIDTH-1:0] mem_wdata,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [MEM_WIDTH-1:0] mem_rdata,
  output logic                 fill_valid,
  output logic [31:0]          fill_addr,
  output logic [LINE_BITS-1:0] fill_data,
  input  logic                 fill_ready,
  output logic                 busy
);

  localparam int             CW         = $clog2(BEATS) + 1;
  localparam logic [CW-1:0]  FULL_CNT   = CW'(BEATS);
  localparam logic [CW-1:0]  LAST_CNT   = CW'(BEATS - 1);
  localparam logic [31:0]    BEAT_BYTES = 32'(MEM_WIDTH / 8);
  localparam logic [31:0]    LINE_MASK  = ~(32'(LINE_BYTES) - 32'd1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    RD   = 2'd2,
    FILL = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [31:0]          r_rd_base;
  logic [31:0]          r_wb_base;
  logic [LINE_BITS-1:0] r_wb_data;
  logic [LINE_BITS-1:0] r_line;
  logic [CW-1:0]        r_wb_cnt;
  logic [CW-1:0]        r_iss_cnt;
  logic [CW-1:0]        r_rcv_cnt;

  logic w_accept;
  logic w_wr_gnt;
  logic w_iss_open;
  logic w_rd_gnt;
  logic w_rcv;

  assign w_accept   = (r_state == IDLE) && req_valid;
  assign w_wr_gnt   = (r_state == WB) && mem_gnt;
  assign w_iss_open = (r_state == RD) && (r_iss_cnt != FULL_CNT);
  assign w_rd_gnt   = w_iss_open && mem_gnt;
  // Responses outside RD, or beyond the last beat, never touch the line.
  assign w_rcv      = (r_state == RD) && (r_rcv_cnt != FULL_CNT) && mem_rvalid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    busy       = 1'b1;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    fill_valid = 1'b0;
    fill_addr  = '0;
    fill_data  = '0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          w_next = req_wb ? WB : RD;
        end
      end
      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = r_wb_base + 32'(r_wb_cnt) * BEAT_BYTES;
        mem_wdata = r_wb_data[r_wb_cnt[CW-2:0]*MEM_WIDTH +: MEM_WIDTH];
        if (mem_gnt && (r_wb_cnt == LAST_CNT)) begin
          w_next = RD;
        end
      end
      RD: begin
        mem_req = w_iss_open;
        if (w_iss_open) begin
          mem_addr = r_rd_base + 32'(r_iss_cnt) * BEAT_BYTES;
        end
        if (w_rcv && (r_rcv_cnt == LAST_CNT)) begin
          w_next = FILL;
        end
      end
      FILL: begin
        fill_valid = 1'b1;
        fill_addr  = r_rd_base;
        fill_data  = r_line;
        if (fill_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_base <= '0;
      r_wb_base <= '0;
      r_wb_data <= '0;
      r_line    <= '0;
      r_wb_cnt  <= '0;
      r_iss_cnt <= '0;
      r_rcv_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_rd_base <= req_addr & LINE_MASK;
        r_wb_base <= wb_addr & LINE_MASK;
        r_wb_data <= wb_data;
        r_wb_cnt  <= '0;
        r_iss_cnt <= '0;
        r_rcv_cnt <= '0;
      end
      if (w_wr_gnt) begin
        r_wb_cnt <= r_wb_cnt + 1'b1;
      end
      if (w_rd_gnt) begin
        r_iss_cnt <= r_iss_cnt + 1'b1;
      end
      if (w_rcv) begin
        r_line[r_rcv_cnt[CW-2:0]*MEM_WIDTH +: MEM_WIDTH] <= mem_rdata;
        r_rcv_cnt <= r_rcv_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// tb_cache_refill_ctrl: directed scenarios for the refill / write-back block.
// Revision: 1.0
// ============================================================================
module tb_cache_refill_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic         req_wb;
  logic [31:0]  wb_addr;
  logic [511:0] wb_data;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_gnt;
  logic         mem_rvalid;
  logic [31:0]  mem_rdata;
  logic         fill_valid;
  logic [31:0]  fill_addr;
  logic [511:0] fill_data;
  logic         fill_ready;
  logic         busy;

  always #5 clk = ~clk;

  cache_refill_ctrl #(.LINE_BYTES(64), .MEM_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wb(req_wb), .wb_addr(wb_addr), .wb_data(wb_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .fill_valid(fill_valid), .fill_addr(fill_addr),
    .fill_data(fill_data), .fill_ready(fill_ready), .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  // What the memory side saw during the last burst, indexed by beat.
  logic [31:0] wr_addr [32];
  logic [31:0] wr_data [32];
  logic [31:0] rd_addr [32];
  int          due     [32];
  int nw, nr, nrcv, first_req_cyc, first_rd_cyc, fill_cyc;
  int hold_err, hold_chk, rdy_busy;
  logic [31:0] rbase;

  function automatic logic [511:0] make_line(input logic [31:0] base);
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[32*k +: 32] = base + 32'(k);
    return l;
  endfunction

  task automatic send_req(input logic [31:0] a, input logic wb,
                          input logic [31:0] wa, input logic [511:0] wd);
    req_addr = a; req_wb = wb; wb_addr = wa; wb_data = wd; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Plays the memory from cycle 1 until fill_valid or the cycle budget runs out.
  task automatic run_burst(input bit toggle, input int lat, input int max_cyc);
    bit tog = 1'b1;
    logic p_req = 1'b0, p_gnt = 1'b0, p_we = 1'b0;
    logic [31:0] p_addr = '0, p_wdata = '0;
    nw = 0; nr = 0; nrcv = 0; first_req_cyc = -1; first_rd_cyc = -1;
    fill_cyc = -1; hold_err = 0; hold_chk = 0; rdy_busy = 0;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      if (fill_valid) begin
        fill_cyc = cyc;
        break;
      end
      if (req_ready) rdy_busy++;
      if (p_req && !p_gnt) begin
        hold_chk++;
        if (!mem_req || mem_addr !== p_addr || mem_we !== p_we ||
            (p_we && mem_wdata !== p_wdata)) hold_err++;
      end
      mem_gnt = toggle ? tog : 1'b1;
      tog = !tog;
      if (mem_req && first_req_cyc < 0) first_req_cyc = cyc;
      if (mem_req && !mem_we && first_rd_cyc < 0) first_rd_cyc = cyc;
      if (mem_req && mem_gnt) begin
        if (mem_we) begin
          if (nw < 32) begin wr_addr[nw] = mem_addr; wr_data[nw] = mem_wdata; end
          nw++;
        end else begin
          if (nr < 32) begin rd_addr[nr] = mem_addr; due[nr] = cyc + lat; end
          nr++;
        end
      end
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      if (nrcv < nr && nrcv < 32 && due[nrcv] == cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rbase + 32'(nrcv);
        nrcv++;
      end
      p_req = mem_req; p_gnt = mem_gnt; p_we = mem_we;
      p_addr = mem_addr; p_wdata = mem_wdata;
      @(negedge clk);
    end
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  task automatic finish_fill();
    fill_ready = 1'b1;
    @(negedge clk);
    fill_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_ctl got req=%b we=%b want 0 0", mem_req, mem_we); end
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_bus got %h %h want 0 0", mem_addr, mem_wdata); end
    checks++; if (fill_valid !== 1'b0 || fill_addr !== 32'h0 || fill_data !== 512'h0) begin errors++; $display("FAIL reset_fill got v=%b a=%h want 0 0", fill_valid, fill_addr); end
  endtask

  task automatic test_clean_miss();
    int bad = 0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL clean_ready got %b want 1", req_ready); end
    rbase = 32'hA000_0000;
    send_req(32'h0001_2345, 1'b0, 32'h0, 512'h0);
    run_burst(1'b0, 1, 60);
    for (int k = 0; k < 16; k++) if (rd_addr[k] !== 32'h0001_2340 + 32'(4*k)) bad++;
    checks++; if (first_req_cyc != 1) begin errors++; $display("FAIL clean_first_req got %0d want 1", first_req_cyc); end
    checks++; if (nw != 0 || nr != 16) begin errors++; $display("FAIL clean_beats got w=%0d r=%0d want 0 16", nw, nr); end
    checks++; if (bad != 0) begin errors++; $display("FAIL clean_rd_addr got %0d bad want 0", bad); end
    checks++; if (fill_cyc != 18) begin errors++; $display("FAIL clean_fill_cycle got %0d want 18", fill_cyc); end
    checks++; if (fill_addr !== 32'h0001_2340) begin errors++; $display("FAIL clean_fill_addr got %h want 00012340", fill_addr); end
    checks++; if (fill_data !== make_line(32'hA000_0000)) begin errors++; $display("FAIL clean_fill_data got %h want %h", fill_data, make_line(32'hA000_0000)); end
    finish_fill();
    checks++; if (req_ready !== 1'b1 || busy !== 1'b0 || fill_valid !== 1'b0) begin errors++; $display("FAIL clean_idle got rdy=%b busy=%b fv=%b want 1 0 0", req_ready, busy, fill_valid); end
  endtask

  task automatic test_dirty_miss();
    int bad = 0;
    rbase = 32'hB000_0000;
    send_req(32'h0004_1008, 1'b1, 32'h0000_8040, make_line(32'h0));
    run_burst(1'b0, 1, 80);
    for (int k = 0; k < 16; k++) begin
      if (wr_addr[k] !== 32'h0000_8040 + 32'(4*k) || wr_data[k] !== 32'(k)) bad++;
      if (rd_addr[k] !== 32'h0004_1000 + 32'(4*k)) bad++;
    end
    checks++; if (nw != 16 || nr != 16) begin errors++; $display("FAIL dirty_beats got w=%0d r=%0d want 16 16", nw, nr); end
    checks++; if (bad != 0) begin errors++; $display("FAIL dirty_addr_data got %0d bad want 0", bad); end
    checks++; if (first_rd_cyc != 17) begin errors++; $display("FAIL dirty_first_read got %0d want 17", first_rd_cyc); end
    checks++; if (fill_cyc != 34) begin errors++; $display("FAIL dirty_fill_cycle got %0d want 34", fill_cyc); end
    checks++; if (fill_addr !== 32'h0004_1000 || fill_data !== make_line(32'hB000_0000)) begin errors++; $display("FAIL dirty_fill got addr %h want 00041000", fill_addr); end
    finish_fill();
  endtask

  task automatic test_backpressure();
    int bad = 0;
    rbase = 32'h1234_0000;
    send_req(32'h0010_00FF, 1'b1, 32'h0000_C07F, make_line(32'h5500_0000));
    run_burst(1'b1, 3, 200);
    for (int k = 0; k < 16; k++) begin
      if (wr_addr[k] !== 32'h0000_C040 + 32'(4*k) || wr_data[k] !== 32'h5500_0000 + 32'(k)) bad++;
      if (rd_addr[k] !== 32'h0010_00C0 + 32'(4*k)) bad++;
    end
    checks++; if (fill_cyc < 0) begin errors++; $display("FAIL bp_fill_timeout got %0d want >0", fill_cyc); end
    checks++; if (hold_err != 0 || hold_chk < 16) begin errors++; $display("FAIL bp_hold got err=%0d chk=%0d want 0 >=16", hold_err, hold_chk); end
    checks++; if (nw != 16 || nr != 16) begin errors++; $display("FAIL bp_grants got w=%0d r=%0d want 16 16", nw, nr); end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_addr_data got %0d bad want 0", bad); end
    checks++; if (fill_data !== make_line(32'h1234_0000)) begin errors++; $display("FAIL bp_fill_data got %h want %h", fill_data, make_line(32'h1234_0000)); end
    finish_fill();
  endtask

  task automatic test_fill_stall();
    rbase = 32'hC000_0000;
    send_req(32'h0002_0040, 1'b0, 32'h0, 512'h0);
    req_addr = 32'h0003_0080; req_wb = 1'b0; req_valid = 1'b1;
    run_burst(1'b0, 1, 60);
    checks++; if (fill_cyc != 18 || rdy_busy != 0) begin errors++; $display("FAIL stall_fill got cyc=%0d rdy=%0d want 18 0", fill_cyc, rdy_busy); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (fill_valid !== 1'b1 || req_ready !== 1'b0 || fill_addr !== 32'h0002_0040 ||
          fill_data !== make_line(32'hC000_0000)) begin
        errors++; $display("FAIL stall_hold cycle %0d got fv=%b rdy=%b addr=%h want 1 0 00020040", i, fill_valid, req_ready, fill_addr);
      end
      @(negedge clk);
    end
    fill_ready = 1'b1;
    @(negedge clk);
    fill_ready = 1'b0;
    checks++; if (req_ready !== 1'b1 || busy !== 1'b0 || fill_valid !== 1'b0) begin errors++; $display("FAIL stall_idle got rdy=%b busy=%b fv=%b want 1 0 0", req_ready, busy, fill_valid); end
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (busy !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 32'h0003_0080) begin errors++; $display("FAIL stall_second_accept got busy=%b req=%b addr=%h want 1 1 00030080", busy, mem_req, mem_addr); end
    rbase = 32'hD000_0000;
    run_burst(1'b0, 1, 60);
    checks++; if (fill_cyc != 18 || fill_addr !== 32'h0003_0080 || fill_data !== make_line(32'hD000_0000)) begin errors++; $display("FAIL stall_second_fill got cyc=%0d addr=%h want 18 00030080", fill_cyc, fill_addr); end
    finish_fill();
  endtask

  task automatic test_reset_mid_wb();
    send_req(32'h0005_5554, 1'b1, 32'h0000_9000, make_line(32'h7700_0000));
    for (int i = 0; i < 7; i++) begin
      mem_gnt = 1'b1;
      @(negedge clk);
    end
    checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h0000_901C || mem_wdata !== 32'h7700_0007) begin errors++; $display("FAIL rstwb_pre got we=%b addr=%h data=%h want 1 0000901c 77000007", mem_we, mem_addr, mem_wdata); end
    mem_gnt = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++; if (req_ready !== 1'b1 || busy !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0 || fill_valid !== 1'b0) begin errors++; $display("FAIL rstwb_ctl got rdy=%b busy=%b req=%b we=%b fv=%b want 1 0 0 0 0", req_ready, busy, mem_req, mem_we, fill_valid); end
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || fill_addr !== 32'h0 || fill_data !== 512'h0) begin errors++; $display("FAIL rstwb_bus got addr=%h wdata=%h faddr=%h want 0 0 0", mem_addr, mem_wdata, fill_addr); end
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    checks++; if (busy !== 1'b0 || fill_valid !== 1'b0 || req_ready !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL rstwb_stray got busy=%b fv=%b rdy=%b want 0 0 1", busy, fill_valid, req_ready); end
    rbase = 32'hE000_0000;
    send_req(32'h0005_5554, 1'b0, 32'h0, 512'h0);
    run_burst(1'b0, 1, 60);
    checks++; if (fill_cyc != 18 || fill_addr !== 32'h0005_5540 || fill_data !== make_line(32'hE000_0000)) begin errors++; $display("FAIL rstwb_new_req got cyc=%0d addr=%h want 18 00055540", fill_cyc, fill_addr); end
    finish_fill();
  endtask

  task automatic test_spurious();
    for (int i = 0; i < 3; i++) begin
      mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0000 + 32'(i); fill_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || req_ready !== 1'b1 || fill_valid !== 1'b0 || mem_req !== 1'b0) begin
        errors++; $display("FAIL spurious cycle %0d got busy=%b rdy=%b fv=%b req=%b want 0 1 0 0", i, busy, req_ready, fill_valid, mem_req);
      end
    end
    mem_rvalid = 1'b0; fill_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_addr = '0; req_wb = 1'b0;
    wb_addr = '0; wb_data = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = '0; fill_ready = 1'b0; rbase = '0;
    @(negedge clk);
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_backpressure();
    test_fill_stall();
    test_reset_mid_wb();
    test_spurious();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
